// File: rtl/poly_mult_pkg.sv
// Shared types and size helpers for the polynomial-multiplier result collector.
// NEGACYCLIC_FOLD_EN selects folding mod x^K+1 (K outputs) instead of 2K-1 linear outputs.
package poly_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  function automatic int unsigned prod_cnt(input int unsigned k);
    return 2 * k - 1;
  endfunction

  function automatic int unsigned out_cnt(input int unsigned k);
`ifdef NEGACYCLIC_FOLD_EN
    return k;
`else
    return 2 * k - 1;
`endif
  endfunction

  function automatic int unsigned idx_w(input int unsigned k);
    return $clog2(2 * k - 1);
  endfunction

  localparam int unsigned N_DEF    = 4;
  localparam int unsigned K_DEF    = 4;
  localparam int unsigned PROD_CNT = prod_cnt(K_DEF);
  localparam int unsigned OUT_CNT  = out_cnt(K_DEF);
  localparam int unsigned IDX_W    = idx_w(K_DEF);

endpackage

// File: rtl/poly_mult_result_collector_buffer.sv
// Coefficient register file: synchronous write, async read, synchronous clear.
// With NEGACYCLIC_FOLD_EN a write may instead subtract the input from the stored entry.
module poly_coef_buffer
  import poly_mult_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 7,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
`ifdef NEGACYCLIC_FOLD_EN
  input  logic          i_sub,
`endif
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata,
  output logic [W-1:0]  o_wr_result
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] w_wr_result;

  // Value that the current write will leave in the addressed entry
  always_comb begin
    w_wr_result = i_wdata;
`ifdef NEGACYCLIC_FOLD_EN
    if (i_sub) begin
      w_wr_result = r_mem[i_waddr] - i_wdata;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= w_wr_result;
    end
  end

  assign o_rdata     = r_mem[i_raddr];
  assign o_wr_result = w_wr_result;

endmodule

// File: rtl/poly_mult_result_collector.sv
// Collects the 2K-1 PE-array diagonal sums and replays them in index order.
// NEGACYCLIC_FOLD_EN folds the product mod x^K+1 while collecting and emits K coefficients.
module poly_mult_result_collector
  import poly_mult_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned K = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [2*N-1:0]        i_in_coef,
  input  logic                  i_in_last,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [2*N-1:0]        o_out_coef,
  output logic [idx_w(K)-1:0]   o_out_idx,
  output logic                  o_out_last,
  output logic                  o_err
);

  localparam int unsigned W     = 2 * N;
  localparam int unsigned IW    = idx_w(K);
  localparam int unsigned PROD  = prod_cnt(K);
  localparam int unsigned OUTC  = out_cnt(K);
  localparam int unsigned BW    = $clog2(OUTC);

  state_e          r_state;
  logic            r_busy;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_err;
  logic [IW-1:0]   r_wcnt;
  logic [IW-1:0]   r_out_idx;
  logic [W-1:0]    r_out_coef;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_last_in;
  logic            w_sub;
  logic [IW-1:0]   w_waddr;
  logic [IW-1:0]   w_raddr;
  logic [W-1:0]    w_rdata;
  logic [W-1:0]    w_wr_result;
  logic [W-1:0]    w_first_coef;

  assign w_in_fire  = i_in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && i_out_ready;
  assign w_last_in  = (r_wcnt == IW'(PROD - 1));

  // Buffer slot for the incoming coefficient; high-order terms fold onto j-K
  always_comb begin
    w_sub   = 1'b0;
    w_waddr = r_wcnt;
`ifdef NEGACYCLIC_FOLD_EN
    if (r_wcnt >= IW'(K)) begin
      w_sub   = 1'b1;
      w_waddr = r_wcnt - IW'(K);
    end
`endif
  end

  // Pre-fetch the entry that becomes visible after the next output handshake
  always_comb begin
    w_raddr = '0;
    if (r_state == ST_DRAIN && r_out_idx != IW'(OUTC - 1)) begin
      w_raddr = r_out_idx + IW'(1);
    end
  end

  // Entry 0 can be updated on the very edge that enters DRAIN, so forward it
  assign w_first_coef = (w_in_fire && w_waddr == '0) ? w_wr_result : w_rdata;

  poly_coef_buffer #(
    .W     (W),
    .DEPTH (OUTC),
    .AW    (BW)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (w_in_fire),
    .i_waddr     (BW'(w_waddr)),
    .i_wdata     (i_in_coef),
`ifdef NEGACYCLIC_FOLD_EN
    .i_sub       (w_sub),
`endif
    .i_raddr     (BW'(w_raddr)),
    .o_rdata     (w_rdata),
    .o_wr_result (w_wr_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_wcnt      <= '0;
      r_out_idx   <= '0;
      r_out_coef  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_COLLECT;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_err      <= 1'b0;
            r_wcnt     <= '0;
          end
        end
        ST_COLLECT: begin
          if (w_in_fire) begin
            if (i_in_last != w_last_in) begin
              r_err <= 1'b1;
            end
            if (w_last_in) begin
              r_state     <= ST_DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_idx   <= '0;
              r_out_coef  <= w_first_coef;
              r_out_last  <= 1'b0;
            end else begin
              r_wcnt <= r_wcnt + IW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_idx   <= '0;
            end else begin
              r_out_idx  <= r_out_idx + IW'(1);
              r_out_coef <= w_rdata;
              r_out_last <= (r_out_idx + IW'(1) == IW'(OUTC - 1));
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_coef  = r_out_coef;
  assign o_out_idx   = r_out_idx;
  assign o_out_last  = r_out_last;
  assign o_err       = r_err;

endmodule

// File: tb/tb_poly_mult_result_collector.sv
// Scoreboard bench for poly_mult_result_collector (N=4, K=4).
// Build with NEGACYCLIC_FOLD_EN defined to check the folded output.
module tb_poly_mult_result_collector;

  localparam int unsigned N    = 4;
  localparam int unsigned K    = 4;
  localparam int unsigned W    = 2 * N;
  localparam int unsigned IW   = 3;
  localparam int unsigned PROD = 2 * K - 1;
`ifdef NEGACYCLIC_FOLD_EN
  localparam int unsigned OUTC = K;
`else
  localparam int unsigned OUTC = PROD;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          o_busy;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [W-1:0]  i_in_coef = '0;
  logic          i_in_last = 1'b0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [W-1:0]  o_out_coef;
  logic [IW-1:0] o_out_idx;
  logic          o_out_last;
  logic          o_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] coef;
    int unsigned  idx;
    logic         last;
  } exp_t;
  exp_t sb[$];

  int          ready_mode = 0;
  int unsigned rcyc = 0;

  logic          stall_prev = 1'b0;
  logic [W-1:0]  held_coef = '0;
  logic [IW-1:0] held_idx = '0;

  always #5 clk = ~clk;

  poly_mult_result_collector #(.N(N), .K(K)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_coef   (i_in_coef),
    .i_in_last   (i_in_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_coef  (o_out_coef),
    .o_out_idx   (o_out_idx),
    .o_out_last  (o_out_last),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Downstream ready pattern: always, 1-0-0 repeating, or random
  always @(posedge clk) begin
    #1;
    rcyc <= rcyc + 1;
    case (ready_mode)
      0:       i_out_ready <= 1'b1;
      1:       i_out_ready <= ((rcyc % 3) == 0);
      default: i_out_ready <= 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: hold stability while stalled, scoreboard compare on handshake
  always @(negedge clk) begin
    if (!i_rst && o_out_valid) begin
      if (stall_prev) begin
        chk("hold_coef", 32'(o_out_coef), 32'(held_coef));
        chk("hold_idx", 32'(o_out_idx), 32'(held_idx));
      end
      chk("in_ready_in_drain", 32'(o_in_ready), 32'd0);
      if (i_out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_output", 32'd1, 32'd0);
        end else begin
          chk("out_coef", 32'(o_out_coef), 32'(sb[0].coef));
          chk("out_idx", 32'(o_out_idx), sb[0].idx);
          chk("out_last", 32'(o_out_last), 32'(sb[0].last));
          void'(sb.pop_front());
        end
      end
    end
    stall_prev <= o_out_valid && !i_out_ready && !i_rst;
    held_coef  <= o_out_coef;
    held_idx   <= o_out_idx;
  end

  // One frame: err_pos<0 marks last correctly, else in_last only at err_pos;
  // abort_after>=0 stops after that many accepts without expecting output.
  task automatic run_frame(input logic [W-1:0] c [PROD], input int err_pos,
                           input bit gaps, input bit noise, input int abort_after);
    exp_t e;
    int   tries;
    if (abort_after < 0) begin
      for (int i = 0; i < int'(OUTC); i++) begin
        e.coef = c[i];
`ifdef NEGACYCLIC_FOLD_EN
        if (i + int'(K) < int'(PROD)) e.coef = W'(c[i] - c[i+int'(K)]);
`endif
        e.idx  = i;
        e.last = (i == int'(OUTC) - 1);
        sb.push_back(e);
      end
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("in_ready_after_start", 32'(o_in_ready), 32'd1);
    chk("err_cleared_by_start", 32'(o_err), 32'd0);
    for (int j = 0; j < int'(PROD); j++) begin
      if (abort_after >= 0 && j == abort_after) return;
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_in_valid = 1'b1;
      i_in_coef  = c[j];
      i_in_last  = (err_pos < 0) ? (j == int'(PROD) - 1) : (j == err_pos);
      if (noise && j == 3) i_start = 1'b1;
      tries = 0;
      while (!o_in_ready && tries < 20) begin
        @(posedge clk); #1;
        tries++;
      end
      if (!o_in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      i_start    = 1'b0;
      i_in_valid = 1'b0;
      i_in_last  = 1'b0;
      if (j == err_pos) chk("err_set", 32'(o_err), 32'd1);
    end
    chk("first_valid_latency", 32'(o_out_valid), 32'd1);
    chk("in_ready_low_drain", 32'(o_in_ready), 32'd0);
    chk("err_after_collect", 32'(o_err), 32'(err_pos >= 0));
    if (noise) begin
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    tries = 0;
    while (tries < 300) begin
      @(negedge clk);
      if (!o_busy && sb.size() == 0) break;
      tries++;
    end
    if (tries >= 300) begin
      chk("drain_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    chk("err_final", 32'(o_err), 32'(err_pos >= 0));
    @(posedge clk); #1;
    chk("idle_out_valid", 32'(o_out_valid), 32'd0);
  endtask

  task automatic rand_coefs(output logic [W-1:0] c [PROD]);
    for (int i = 0; i < int'(PROD); i++) c[i] = W'($urandom_range(0, 255));
  endtask

  logic [W-1:0] cf [PROD];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_last", 32'(o_out_last), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_out_idx", 32'(o_out_idx), 32'd0);
    chk("rst_out_coef", 32'(o_out_coef), 32'd0);

    // Basic frame: a=[1,2,3,4] * b=[1,1,1,1]
    ready_mode = 0;
    cf = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd9, 8'd7, 8'd4};
    run_frame(cf, -1, 1'b0, 1'b0, -1);

    // Backpressure with input gaps
    ready_mode = 1;
    rand_coefs(cf);
    run_frame(cf, -1, 1'b1, 1'b0, -1);
    ready_mode = 2;
    rand_coefs(cf);
    run_frame(cf, -1, 1'b1, 1'b0, -1);

    // Framing error on the 3rd input, then a clean frame clears it
    ready_mode = 0;
    rand_coefs(cf);
    run_frame(cf, 2, 1'b0, 1'b0, -1);
    ready_mode = 1;
    rand_coefs(cf);
    run_frame(cf, -1, 1'b0, 1'b0, -1);

    // Reset mid-collect after 3 accepts, then a fresh frame
    ready_mode = 0;
    rand_coefs(cf);
    run_frame(cf, -1, 1'b0, 1'b0, 3);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_out_valid", 32'(o_out_valid), 32'd0);
    chk("abort_in_ready", 32'(o_in_ready), 32'd0);
    chk("abort_out_coef", 32'(o_out_coef), 32'd0);
    rand_coefs(cf);
    run_frame(cf, -1, 1'b0, 1'b0, -1);

    // start pulses during COLLECT and DRAIN are ignored
    ready_mode = 1;
    cf = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd9, 8'd7, 8'd4};
    run_frame(cf, -1, 1'b0, 1'b1, -1);
    rand_coefs(cf);
    run_frame(cf, -1, 1'b1, 1'b1, -1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_mult_result_collector.md
Name: poly_mult_result_collector

Overview:
Downstream drain stage for the systolic polynomial-multiplier PE array.
- Accepts the 2K-1 diagonal sums (product coefficients c0..c(2K-2)) as the array emits them, one per cycle under valid/ready.
- Buffers them and replays them in index order on a valid/ready output stream to the next stage (NTT/reduction path).
- Width of every coefficient matches the PE diagonal output: 2N bits, modulo 2^(2N).

Parameters:
N, 4, PE coefficient width; stored and streamed coefficients are 2N bits
K, 4, coefficients per input polynomial; product has 2K-1 coefficients (K >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new collection; honoured only in IDLE
busy  output  1  high in COLLECT or DRAIN
in_valid  input  1  in_coef valid
in_ready  output  1  collector can accept; high only in COLLECT
in_coef  input  2N  diagonal sum from PE array
in_last  input  1  upstream marks final coefficient
out_valid  output  1  out_coef valid
out_ready  input  1  downstream accepts
out_coef  output  2N  buffered coefficient
out_idx  output  $clog2(2K-1)  index of out_coef
out_last  output  1  high with final output coefficient
err  output  1  sticky framing error

Behaviour:
- Reset: state IDLE; busy, in_ready, out_valid, out_last, err = 0; out_idx = 0; out_coef = 0; write/read counters = 0; buffer cleared to 0. Reset mid-operation aborts immediately, with no partial output.
- FSM:
  - IDLE -> COLLECT on start. err cleared and write counter zeroed on that same edge.
  - COLLECT -> DRAIN on the edge accepting coefficient index 2K-2.
  - DRAIN -> IDLE on the out handshake with out_last = 1.
- start in COLLECT or DRAIN: ignored, no effect.
- Input handshake: a transfer occurs when in_valid && in_ready.
  - Coefficient j (write-counter value) is written to buf[j].
  - Counter increments by 1 per transfer and never wraps within a frame.
- in_last check, evaluated on each accepted transfer:
  - in_last = 1 at j != 2K-2 sets err.
  - in_last = 0 at j = 2K-2 sets err.
  - Collection length is governed by the counter only; in_last never ends a frame early.
- Output:
  - out_valid = 1 throughout DRAIN. First valid is the cycle after the last input transfer (latency 1).
  - out_coef = buf[rd], out_idx = rd. Both are held stable while out_valid && !out_ready.
  - rd increments on each handshake.
  - out_last = 1 when rd = OUT_CNT-1.
- OUT_CNT = 2K-1 (fold disabled) or K (fold enabled).
- Back-to-back frames: start may be asserted the cycle after returning to IDLE. There is no overlap of DRAIN with the next COLLECT.
- Arithmetic: all subtraction is modulo 2^(2N) (wrap, no saturation).

Optional Feature:
Macro NEGACYCLIC_FOLD_EN.
- Defined: on-the-fly reduction mod x^K+1.
  - For j < K: buf[j] = in_coef.
  - For j >= K: buf[j-K] = buf[j-K] - in_coef. That entry was always written in an earlier cycle.
  - Buffer depth is K; OUT_CNT = K; out_idx range 0..K-1.
- Undefined: plain linear product. Buffer depth is 2K-1; OUT_CNT = 2K-1; no subtractor is synthesised.

Decomposition:
- poly_mult_pkg holds:
  - FSM state encoding (IDLE, COLLECT, DRAIN).
  - PROD_CNT = 2K-1 and OUT_CNT.
  - Index width $clog2(2K-1).
- Natural sub-module: poly_coef_buffer, a synchronous-write, async-read register file of 2N-bit entries.
  - Parameterised depth.
  - Synchronous clear on rst.
  - Optional read-modify-write subtract port used under NEGACYCLIC_FOLD_EN.

Test Plan (N=4, K=4):
- Basic: a=[1,2,3,4] and b=[1,1,1,1] give inputs 1,3,6,10,9,7,4, with in_last on the 7th and out_ready=1 -> outputs 1,3,6,10,9,7,4 with idx 0..6, out_last at idx 6, first out_valid one cycle after the 7th accept, err=0.
- Fold (NEGACYCLIC_FOLD_EN), same input -> outputs 248,252,2,10 (idx 0..3), out_last at idx 3.
- Backpressure: toggle out_ready 1,0,0,1,... and insert in_valid gaps -> out_coef/out_idx stable while stalled, no coefficient lost or duplicated, in_ready=0 in DRAIN.
- Framing error: in_last=1 on the 3rd input -> err=1 sticky through DRAIN; the remaining 4 inputs are still collected and all 7 coefficients are output; the next start clears err.
- Reset mid-COLLECT after 3 accepts:
  - Expected next cycle: busy=0, out_valid=0, buffer zero.
  - A fresh frame then produces correct results.
- start asserted during COLLECT and DRAIN -> no counter reset, output sequence unchanged.
